// File: rtl/mips_bus_pkg.sv
// mips_bus_pkg: shared state encoding and constants for the CPU bus arbiter
package mips_bus_pkg;
  typedef enum logic [1:0] {IDLE, BUS_I, BUS_D, DONE} arb_state_t;
  localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'hBFC00000;
  localparam logic [3:0] BE_WORD = 4'b1111;
endpackage

// File: rtl/mips_bus_wait_timer.sv
// mips_bus_wait_timer: counts stalled bus edges, flags the edge that reaches MAX_WAIT
//   clk, reset (async active-low); clr holds the count at 0; inc counts one stall edge;
//   expired is high on the stall edge that brings the count to MAX_WAIT.
module mips_bus_wait_timer #(
  parameter int MAX_WAIT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic inc,
  output logic expired
);
  localparam int CW = $clog2(MAX_WAIT + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  assign expired = inc && cnt_q == CW'(MAX_WAIT - 1);
  always_comb cnt_d = clr ? '0 : inc ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge clk or negedge reset)
    if (!reset) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/mips_bus_arbiter.sv
// mips_bus_arbiter: shares one Avalon-style master between fetch (I) and load/store (D)
//   clk, reset (async active-low); I side: i_req/i_addr -> i_rdata/i_ack;
//   D side: d_req/d_write/d_addr/d_wdata/d_byteenable -> d_rdata/d_ack;
//   bus: address/write/read/writedata/byteenable out, waitrequest/readdata in; bus_error.
//   Optional macro MIPS_BUS_ARB_TIMEOUT_EN aborts a transfer after MAX_WAIT stall edges.
module mips_bus_arbiter
  import mips_bus_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEFAULT
`ifdef MIPS_BUS_ARB_TIMEOUT_EN
  , parameter int MAX_WAIT = 16
`endif
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic [31:0] i_rdata,
  output logic        i_ack,
  input  logic        d_req,
  input  logic        d_write,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_byteenable,
  output logic [31:0] d_rdata,
  output logic        d_ack,
  output logic [31:0] address,
  output logic        write,
  output logic        read,
  input  logic        waitrequest,
  output logic [31:0] writedata,
  output logic [3:0]  byteenable,
  input  logic [31:0] readdata,
  output logic        bus_error
);
  arb_state_t state_q, state_d;
  logic [31:0] address_q, address_d, writedata_q, writedata_d;
  logic [31:0] i_rdata_q, i_rdata_d, d_rdata_q, d_rdata_d;
  logic [3:0] be_q, be_d;
  logic read_q, read_d, write_q, write_d;
  logic i_ack_q, i_ack_d, d_ack_q, d_ack_d, bus_error_q, bus_error_d;
  logic busy, timeout;
  assign busy = state_q == BUS_I || state_q == BUS_D;
`ifdef MIPS_BUS_ARB_TIMEOUT_EN
  mips_bus_wait_timer #(.MAX_WAIT(MAX_WAIT)) u_timer (
    .clk(clk), .reset(reset), .clr(!busy), .inc(busy && waitrequest), .expired(timeout)
  );
`else
  assign timeout = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    address_d = address_q;
    writedata_d = writedata_q;
    be_d = be_q;
    read_d = read_q;
    write_d = write_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    i_ack_d = 1'b0;
    d_ack_d = 1'b0;
    bus_error_d = bus_error_q;
    case (state_q)
      IDLE:
        if (d_req) begin
          state_d = BUS_D;
          address_d = d_addr;
          read_d = !d_write;
          write_d = d_write;
          be_d = d_byteenable;
          writedata_d = d_write ? d_wdata : writedata_q;
        end else if (i_req) begin
          state_d = BUS_I;
          address_d = i_addr;
          read_d = 1'b1;
          write_d = 1'b0;
          be_d = BE_WORD;
        end
      BUS_I, BUS_D:
        // timeout only fires while stalled, so it never coincides with a real completion
        if (!waitrequest || timeout) begin
          state_d = DONE;
          address_d = RESET_VECTOR;
          read_d = 1'b0;
          write_d = 1'b0;
          be_d = '0;
          i_ack_d = state_q == BUS_I;
          d_ack_d = state_q == BUS_D;
          i_rdata_d = state_q != BUS_I ? i_rdata_q : timeout ? '0 : readdata;
          d_rdata_d = state_q != BUS_D ? d_rdata_q : timeout ? '0 : read_q ? readdata : d_rdata_q;
          bus_error_d = bus_error_q || timeout;
        end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q <= IDLE;
      address_q <= RESET_VECTOR;
      writedata_q <= '0;
      be_q <= '0;
      read_q <= 1'b0;
      write_q <= 1'b0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
      i_ack_q <= 1'b0;
      d_ack_q <= 1'b0;
      bus_error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      address_q <= address_d;
      writedata_q <= writedata_d;
      be_q <= be_d;
      read_q <= read_d;
      write_q <= write_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
      i_ack_q <= i_ack_d;
      d_ack_q <= d_ack_d;
      bus_error_q <= bus_error_d;
    end
  assign address = address_q;
  assign writedata = writedata_q;
  assign byteenable = be_q;
  assign read = read_q;
  assign write = write_q;
  assign i_rdata = i_rdata_q;
  assign d_rdata = d_rdata_q;
  assign i_ack = i_ack_q;
  assign d_ack = d_ack_q;
  assign bus_error = bus_error_q;
endmodule

// File: tb/tb_mips_bus_arbiter.sv
// tb_mips_bus_arbiter: transaction-level checking of the fetch/data bus arbiter
module tb_mips_bus_arbiter;
  localparam logic [31:0] RV = 32'hBFC00000;
  logic clk = 1'b0, reset = 1'b0;
  logic i_req = 0, d_req = 0, d_write = 0, waitrequest = 0;
  logic [31:0] i_addr = 0, d_addr = 0, d_wdata = 0, readdata = 0;
  logic [3:0] d_byteenable = 0;
  logic [31:0] i_rdata, d_rdata, address, writedata;
  logic [3:0] byteenable;
  logic i_ack, d_ack, write, read, bus_error;
  always #5 clk = ~clk;
  mips_bus_arbiter dut (
    .clk(clk), .reset(reset), .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack),
    .d_req(d_req), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_byteenable(d_byteenable), .d_rdata(d_rdata), .d_ack(d_ack), .address(address),
    .write(write), .read(read), .waitrequest(waitrequest), .writedata(writedata),
    .byteenable(byteenable), .readdata(readdata), .bus_error(bus_error)
  );
  typedef struct {
    logic i_en, d_en, dw;
    logic [31:0] ia, da, wd;
    logic [3:0] be;
    int wi, wdw;
    logic [31:0] ri, rd;
  } vec_t;
  int checks = 0, errors = 0;
  logic [31:0] wd_exp = 0, ir_exp = 0, dr_exp = 0;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", n, a, e, $time);
    end
  endtask
  task automatic chk_bus(input string n, input logic rd, input logic wr, input logic [31:0] ad,
                         input logic [3:0] be, input logic ia, input logic da);
    chk({n, ".read"}, 32'(read), 32'(rd));
    chk({n, ".write"}, 32'(write), 32'(wr));
    chk({n, ".address"}, address, ad);
    chk({n, ".byteenable"}, 32'(byteenable), 32'(be));
    chk({n, ".writedata"}, writedata, wd_exp);
    chk({n, ".i_ack"}, 32'(i_ack), 32'(ia));
    chk({n, ".d_ack"}, 32'(d_ack), 32'(da));
    chk({n, ".i_rdata"}, i_rdata, ir_exp);
    chk({n, ".d_rdata"}, d_rdata, dr_exp);
    chk({n, ".bus_error"}, 32'(bus_error), 0);
  endtask
  // Drives one request pattern; D is expected first, then I, each with its own stall count.
  task automatic xfer(input string n, input vec_t v);
    i_req = v.i_en; d_req = v.d_en; i_addr = v.ia; d_addr = v.da; d_write = v.dw;
    d_wdata = v.wd; d_byteenable = v.be; waitrequest = 0;
    if (!v.i_en && !v.d_en) begin
      @(negedge clk);
      chk_bus({n, ".noreq"}, 0, 0, RV, 0, 0, 0);
      return;
    end
    for (int t = 0; t < 2; t++) begin
      bit is_d = t == 0;
      int w;
      if (is_d ? !v.d_en : !v.i_en) continue;
      w = is_d ? v.wdw : v.wi;
      if (is_d && v.dw) wd_exp = v.wd;
      @(posedge clk);
      for (int k = 0; k <= w; k++) begin
        @(negedge clk);
        if (is_d) chk_bus({n, ".d_strobe"}, !v.dw, v.dw, v.da, v.be, 0, 0);
        else chk_bus({n, ".i_strobe"}, 1, 0, v.ia, 4'hF, 0, 0);
        waitrequest = k < w;
        readdata = k < w ? $urandom : is_d ? v.rd : v.ri;
        i_addr = $urandom; d_addr = $urandom; d_wdata = $urandom;
        d_byteenable = 4'($urandom); d_write = 1'($urandom);
      end
      @(posedge clk);
      @(negedge clk);
      if (is_d) begin
        if (!v.dw) dr_exp = v.rd;
        chk_bus({n, ".d_ack"}, 0, 0, RV, 0, 0, 1);
        d_req = 0;
      end else begin
        ir_exp = v.ri;
        chk_bus({n, ".i_ack"}, 0, 0, RV, 0, 1, 0);
        i_req = 0;
      end
      i_addr = v.ia; d_addr = v.da; d_write = v.dw; d_wdata = v.wd; d_byteenable = v.be;
      waitrequest = 1'($urandom);
      readdata = $urandom;
      @(posedge clk);
      @(negedge clk);
      chk_bus({n, ".done"}, 0, 0, RV, 0, 0, 0);
      waitrequest = 0;
    end
  endtask
  vec_t vecs[5];
  initial begin
    vecs[0] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    vecs[1] = '{1, 0, 0, 32'hBFC00000, 0, 0, 0, 0, 0, 32'h3C021234, 0};
    vecs[2] = '{0, 1, 0, 0, 32'h00001000, 0, 4'hF, 0, 3, 0, 32'h06C20000};
    vecs[3] = '{1, 1, 1, 32'hBFC00004, 32'h00002000, 32'hDEADBEEF, 4'b0011, 0, 0,
                32'h24420001, 32'h55555555};
    vecs[4] = '{1, 1, 0, 32'hBFC00008, 32'h00002004, 32'h12345678, 4'b1100, 2, 1,
                32'h8C430000, 32'hCAFEF00D};
    repeat (3) @(negedge clk);
    chk_bus("in_reset", 0, 0, RV, 0, 0, 0);
    reset = 1;
    @(negedge clk);
    chk_bus("after_reset", 0, 0, RV, 0, 0, 0);
    for (int i = 0; i < 5; i++) xfer($sformatf("vec%0d", i), vecs[i]);
    for (int i = 0; i < 40; i++) begin
      vec_t r;
      r.i_en = 1'($urandom); r.d_en = 1'($urandom); r.dw = 1'($urandom);
      r.ia = $urandom; r.da = $urandom; r.wd = $urandom; r.be = 4'($urandom);
      r.wi = $urandom_range(0, 3); r.wdw = $urandom_range(0, 3);
      r.ri = $urandom; r.rd = $urandom;
      xfer($sformatf("rnd%0d", i), r);
    end
    d_req = 1; d_write = 0; d_addr = 32'h00003000; d_byteenable = 4'hF; waitrequest = 1;
    @(posedge clk);
    @(negedge clk);
    chk("midrst.read_before", 32'(read), 1);
    #2 reset = 0;
    #1;
    wd_exp = 0; ir_exp = 0; dr_exp = 0;
    chk_bus("midrst.async", 0, 0, RV, 0, 0, 0);
    d_req = 0; waitrequest = 0;
    @(negedge clk);
    reset = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk_bus("midrst.idle", 0, 0, RV, 0, 0, 0);
    end
    xfer("post_rst", vecs[1]);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
